// File: rtl/nn_pkg.sv
// Shared types and helpers for the epoch sequencer slice.
package nn_pkg;

  localparam int unsigned BITS_DEF  = 16;
  localparam int unsigned ACC_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE,
    TR_ISSUE,
    TR_WAIT,
    VL_ISSUE,
    VL_WAIT,
    EPOCH_END,
    DONE
  } seq_state_t;

  // Unsigned add clamped to max; callers keep operands within 64 bits.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic [63:0] max);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max}) ? max : s[63:0];
  endfunction

endpackage

// File: rtl/nn_sample_counter.sv
// Per-phase sample index with terminal-count detect; wraps to zero on the last sample.
module nn_sample_counter
  import nn_pkg::*;
#(
  parameter int unsigned BITS = BITS_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            inc,
  input  logic [BITS-1:0] limit,
  output logic            last_c
);

  logic [BITS-1:0] idx_q, idx_d;

  always_comb begin
    last_c = (BITS'(idx_q + BITS'(1)) == limit);
    idx_d  = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (inc) begin
      idx_d = last_c ? '0 : BITS'(idx_q + BITS'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) idx_q <= '0;
    else        idx_q <= idx_d;
  end

endmodule

// File: rtl/nn_epoch_sequencer.sv
// Epoch controller: strobes Pattern through train/validation samples and tracks the best epoch.
module nn_epoch_sequencer
  import nn_pkg::*;
#(
  parameter int unsigned BITS  = BITS_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [BITS-1:0]  n_train,
  input  logic [BITS-1:0]  n_valid,
  input  logic [BITS-1:0]  n_epochs,
  input  logic             net_done,
  input  logic [BITS-1:0]  err,
  output logic             tr,
  output logic             vl,
  output logic             sw,
  output logic             busy,
  output logic             done,
  output logic [BITS-1:0]  epoch_cnt,
  output logic [ACC_W-1:0] val_err_sum,
  output logic [ACC_W-1:0] best_err,
  output logic [BITS-1:0]  best_epoch
);

  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

  seq_state_t       state_q, state_d;
  logic [BITS-1:0]  n_train_q, n_train_d;
  logic [BITS-1:0]  n_valid_q, n_valid_d;
  logic [BITS-1:0]  n_epochs_q, n_epochs_d;
  logic [BITS-1:0]  epoch_cnt_q, epoch_cnt_d;
  logic [ACC_W-1:0] val_err_sum_q, val_err_sum_d;
  logic [ACC_W-1:0] best_err_q, best_err_d;
  logic [BITS-1:0]  best_epoch_q, best_epoch_d;
  logic             tr_q, tr_d, vl_q, vl_d, sw_q, sw_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             cnt_clr, cnt_inc, sample_last_c;
  logic [BITS-1:0]  cnt_limit_c;

  assign cnt_limit_c = (state_q == VL_WAIT) ? n_valid_q : n_train_q;

  nn_sample_counter #(.BITS(BITS)) u_sample_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .limit  (cnt_limit_c),
    .last_c (sample_last_c)
  );

  // Next state and register updates; strobes are decoded from the next state so they register cleanly.
  always_comb begin
    state_d       = state_q;
    n_train_d     = n_train_q;
    n_valid_d     = n_valid_q;
    n_epochs_d    = n_epochs_q;
    epoch_cnt_d   = epoch_cnt_q;
    val_err_sum_d = val_err_sum_q;
    best_err_d    = best_err_q;
    best_epoch_d  = best_epoch_q;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && (n_train != '0) && (n_epochs != '0)) begin
            n_train_d     = n_train;
            n_valid_d     = n_valid;
            n_epochs_d    = n_epochs;
            epoch_cnt_d   = '0;
            val_err_sum_d = '0;
            best_err_d    = ACC_MAX;
            best_epoch_d  = '0;
            cnt_clr       = 1'b1;
            state_d       = TR_ISSUE;
          end
        end
        TR_ISSUE: state_d = TR_WAIT;
        TR_WAIT: begin
          if (net_done) begin
            cnt_inc = 1'b1;
            if (!sample_last_c)        state_d = TR_ISSUE;
            else if (n_valid_q == '0)  state_d = EPOCH_END;
            else                       state_d = VL_ISSUE;
          end
        end
        VL_ISSUE: state_d = VL_WAIT;
        VL_WAIT: begin
          if (net_done) begin
            cnt_inc       = 1'b1;
            val_err_sum_d = ACC_W'(sat_add(64'(val_err_sum_q), 64'(err), 64'(ACC_MAX)));
            state_d       = sample_last_c ? EPOCH_END : VL_ISSUE;
          end
        end
        EPOCH_END: begin
          if (val_err_sum_q < best_err_q) begin
            best_err_d   = val_err_sum_q;
            best_epoch_d = epoch_cnt_q;
          end
          epoch_cnt_d = BITS'(epoch_cnt_q + BITS'(1));
          if (epoch_cnt_d == n_epochs_q) begin
            state_d = DONE;
          end else begin
            state_d       = TR_ISSUE;
            val_err_sum_d = '0;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    tr_d   = (state_d == TR_ISSUE);
    vl_d   = (state_d == VL_ISSUE);
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE) && (state_d != DONE);
    sw_d   = (state_d == EPOCH_END) && (val_err_sum_d < best_err_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      n_train_q     <= '0;
      n_valid_q     <= '0;
      n_epochs_q    <= '0;
      epoch_cnt_q   <= '0;
      val_err_sum_q <= '0;
      best_err_q    <= ACC_MAX;
      best_epoch_q  <= '0;
      tr_q          <= 1'b0;
      vl_q          <= 1'b0;
      sw_q          <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      n_train_q     <= n_train_d;
      n_valid_q     <= n_valid_d;
      n_epochs_q    <= n_epochs_d;
      epoch_cnt_q   <= epoch_cnt_d;
      val_err_sum_q <= val_err_sum_d;
      best_err_q    <= best_err_d;
      best_epoch_q  <= best_epoch_d;
      tr_q          <= tr_d;
      vl_q          <= vl_d;
      sw_q          <= sw_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign tr          = tr_q;
  assign vl          = vl_q;
  assign sw          = sw_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign epoch_cnt   = epoch_cnt_q;
  assign val_err_sum = val_err_sum_q;
  assign best_err    = best_err_q;
  assign best_epoch  = best_epoch_q;

endmodule

// File: tb/tb_nn_epoch_sequencer.sv
// Directed bench for nn_epoch_sequencer: table of whole runs plus hand-timed abort/reset/spurious sequences.
module tb_nn_epoch_sequencer;

  localparam int unsigned BITS  = 16;
  localparam int unsigned ACC_W = 17;
  localparam int NV = 5;

  logic             clk = 1'b0;
  logic             rst_n, start, abort, net_done;
  logic [BITS-1:0]  n_train, n_valid, n_epochs, err;
  logic             tr, vl, sw, busy, done;
  logic [BITS-1:0]  epoch_cnt, best_epoch;
  logic [ACC_W-1:0] val_err_sum, best_err;

  nn_epoch_sequencer #(.BITS(BITS), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .n_train(n_train), .n_valid(n_valid), .n_epochs(n_epochs),
    .net_done(net_done), .err(err),
    .tr(tr), .vl(vl), .sw(sw), .busy(busy), .done(done),
    .epoch_cnt(epoch_cnt), .val_err_sum(val_err_sum),
    .best_err(best_err), .best_epoch(best_epoch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] nt, nv, ne;
    logic [15:0] errs [12];
    int          exp_tr, exp_vl, exp_sw, exp_lat;
    logic [15:0] exp_epoch, exp_best_ep;
    logic [16:0] exp_best, exp_sum;
  } vec_t;

  vec_t        vecs [NV];
  logic [15:0] cur_errs [12];
  int          eidx;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Network model: answers every tr/vl with net_done in the following cycle.
  task automatic step();
    logic        nx;
    logic [15:0] ex;
    nx = tr | vl;
    ex = 16'h0111;
    if (vl) begin
      ex = (eidx < 12) ? cur_errs[eidx] : 16'h0000;
      eidx++;
    end
    tick();
    net_done = nx;
    err      = nx ? ex : 16'h0BAD;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".tr"}, 64'(tr), 64'(0));
    chk({tag, ".vl"}, 64'(vl), 64'(0));
    chk({tag, ".sw"}, 64'(sw), 64'(0));
    chk({tag, ".busy"}, 64'(busy), 64'(0));
    chk({tag, ".done"}, 64'(done), 64'(0));
    chk({tag, ".epoch_cnt"}, 64'(epoch_cnt), 64'(0));
    chk({tag, ".val_err_sum"}, 64'(val_err_sum), 64'(0));
    chk({tag, ".best_err"}, 64'(best_err), 64'h1FFFF);
    chk({tag, ".best_epoch"}, 64'(best_epoch), 64'(0));
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc, done_cyc, n_tr, n_vl, n_sw;
    logic excl_bad, wrap_bad, busy_first, busy_at_done;
    logic [ACC_W-1:0] prev_sum;
    n_train  = v.nt;
    n_valid  = v.nv;
    n_epochs = v.ne;
    cur_errs = v.errs;
    eidx     = 0;
    net_done = 1'b0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    cyc = 1; done_cyc = -1; n_tr = 0; n_vl = 0; n_sw = 0;
    excl_bad = 1'b0; wrap_bad = 1'b0; busy_at_done = 1'b1;
    busy_first = busy;
    prev_sum = '0;
    while ((cyc < 2000) && (done_cyc < 0)) begin
      n_tr += int'(tr);
      n_vl += int'(vl);
      n_sw += int'(sw);
      if ((int'(tr) + int'(vl) + int'(sw)) > 1) excl_bad = 1'b1;
      if ((val_err_sum < prev_sum) && (val_err_sum != '0)) wrap_bad = 1'b1;
      prev_sum = val_err_sum;
      if (done) begin
        done_cyc     = cyc;
        busy_at_done = busy;
      end else begin
        step();
        cyc++;
      end
    end
    chk({tag, ".busy_first"}, 64'(busy_first), 64'(1));
    chk({tag, ".done_cycle"}, 64'(done_cyc), 64'(v.exp_lat));
    chk({tag, ".tr_pulses"}, 64'(n_tr), 64'(v.exp_tr));
    chk({tag, ".vl_pulses"}, 64'(n_vl), 64'(v.exp_vl));
    chk({tag, ".sw_pulses"}, 64'(n_sw), 64'(v.exp_sw));
    chk({tag, ".strobe_excl"}, 64'(excl_bad), 64'(0));
    chk({tag, ".no_wrap"}, 64'(wrap_bad), 64'(0));
    chk({tag, ".busy_at_done"}, 64'(busy_at_done), 64'(0));
    chk({tag, ".epoch_cnt"}, 64'(epoch_cnt), 64'(v.exp_epoch));
    chk({tag, ".best_err"}, 64'(best_err), 64'(v.exp_best));
    chk({tag, ".best_epoch"}, 64'(best_epoch), 64'(v.exp_best_ep));
    chk({tag, ".val_err_sum"}, 64'(val_err_sum), 64'(v.exp_sum));
    step();
    chk({tag, ".done_1cyc"}, 64'(done), 64'(0));
    chk({tag, ".idle_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    // Whole-run table: latency = epochs*(2*n_train + 2*n_valid + 1) + 1 cycles from start.
    vecs[0].nt = 4; vecs[0].nv = 0; vecs[0].ne = 1;
    vecs[0].errs = '{default: 16'h0};
    vecs[0].exp_tr = 4; vecs[0].exp_vl = 0; vecs[0].exp_sw = 1; vecs[0].exp_lat = 10;
    vecs[0].exp_epoch = 1; vecs[0].exp_best_ep = 0; vecs[0].exp_best = 0; vecs[0].exp_sum = 0;

    vecs[1].nt = 2; vecs[1].nv = 3; vecs[1].ne = 3;
    vecs[1].errs = '{16'd10, 16'd10, 16'd10, 16'd5, 16'd5, 16'd10, 16'd5, 16'd10, 16'd10, 16'd0, 16'd0, 16'd0};
    vecs[1].exp_tr = 6; vecs[1].exp_vl = 9; vecs[1].exp_sw = 2; vecs[1].exp_lat = 34;
    vecs[1].exp_epoch = 3; vecs[1].exp_best_ep = 1; vecs[1].exp_best = 20; vecs[1].exp_sum = 25;

    vecs[2].nt = 1; vecs[2].nv = 4; vecs[2].ne = 2;
    vecs[2].errs = '{default: 16'hFFFF};
    vecs[2].exp_tr = 2; vecs[2].exp_vl = 8; vecs[2].exp_sw = 0; vecs[2].exp_lat = 23;
    vecs[2].exp_epoch = 2; vecs[2].exp_best_ep = 0; vecs[2].exp_best = 17'h1FFFF; vecs[2].exp_sum = 17'h1FFFF;

    vecs[3].nt = 1; vecs[3].nv = 1; vecs[3].ne = 2;
    vecs[3].errs = '{16'd7, 16'd7, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    vecs[3].exp_tr = 2; vecs[3].exp_vl = 2; vecs[3].exp_sw = 1; vecs[3].exp_lat = 11;
    vecs[3].exp_epoch = 2; vecs[3].exp_best_ep = 0; vecs[3].exp_best = 7; vecs[3].exp_sum = 7;

    vecs[4].nt = 3; vecs[4].nv = 2; vecs[4].ne = 2;
    vecs[4].errs = '{16'd9, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    vecs[4].exp_tr = 6; vecs[4].exp_vl = 4; vecs[4].exp_sw = 2; vecs[4].exp_lat = 23;
    vecs[4].exp_epoch = 2; vecs[4].exp_best_ep = 1; vecs[4].exp_best = 0; vecs[4].exp_sum = 0;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; net_done = 1'b0; err = '0;
    n_train = '0; n_valid = '0; n_epochs = '0; eidx = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk_reset("reset");

    for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Abort in VL_WAIT together with net_done: sample dropped, no done.
    n_train = 1; n_valid = 2; n_epochs = 2;
    cur_errs = '{16'd5, 16'd100, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    eidx = 0; start = 1'b1;
    tick();
    start = 1'b0;
    step(); step(); step(); step();
    chk("abort.sum_before", 64'(val_err_sum), 64'(5));
    chk("abort.vl_before", 64'(vl), 64'(1));
    step();
    abort = 1'b1;
    tick();
    abort = 1'b0; net_done = 1'b0;
    chk("abort.busy", 64'(busy), 64'(0));
    chk("abort.done", 64'(done), 64'(0));
    chk("abort.vl", 64'(vl), 64'(0));
    chk("abort.sum_frozen", 64'(val_err_sum), 64'(5));
    chk("abort.epoch_frozen", 64'(epoch_cnt), 64'(0));
    tick();
    chk("abort.no_done_later", 64'(done), 64'(0));
    chk("abort.still_idle", 64'(busy | tr), 64'(0));
    run_vec(vecs[1], "after_abort");

    // Synchronous reset while waiting in TR_WAIT of epoch 1.
    n_train = 1; n_valid = 1; n_epochs = 3;
    cur_errs = '{16'd3, 16'd3, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    eidx = 0; start = 1'b1;
    tick();
    start = 1'b0;
    step(); step(); step(); step();
    chk("rst_mid.sw_epoch0", 64'(sw), 64'(1));
    step();
    chk("rst_mid.tr", 64'(tr), 64'(1));
    chk("rst_mid.epoch_cnt", 64'(epoch_cnt), 64'(1));
    chk("rst_mid.best_err", 64'(best_err), 64'(3));
    step();
    rst_n = 1'b0; net_done = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_reset("rst_mid");

    // Zero-count starts are ignored.
    n_train = 2; n_valid = 1; n_epochs = 0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_ep.busy", 64'(busy), 64'(0));
    tick();
    chk("zero_ep.tr", 64'(tr | busy), 64'(0));
    n_train = 0; n_epochs = 2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("zero_tr.idle", 64'(tr | busy), 64'(0));

    // Spurious net_done in IDLE and TR_ISSUE, start while busy.
    net_done = 1'b1; err = 16'd50;
    tick(); tick();
    chk("spur_idle.sum", 64'(val_err_sum), 64'(0));
    chk("spur_idle.quiet", 64'(tr | busy | done), 64'(0));
    n_train = 2; n_valid = 1; n_epochs = 1; start = 1'b1; net_done = 1'b0;
    tick();
    chk("spur.tr1", 64'(tr), 64'(1));
    n_epochs = 5; net_done = 1'b1; err = 16'd77;
    tick();
    chk("spur.tr_issue_ignored", 64'(tr), 64'(0));
    chk("spur.busy", 64'(busy), 64'(1));
    start = 1'b0; n_epochs = 1; net_done = 1'b1; err = 16'd1;
    tick();
    chk("spur.tr2", 64'(tr), 64'(1));
    net_done = 1'b0;
    tick();
    net_done = 1'b1;
    tick();
    chk("spur.vl", 64'(vl), 64'(1));
    net_done = 1'b0;
    tick();
    net_done = 1'b1; err = 16'd4;
    tick();
    net_done = 1'b0;
    chk("spur.sw", 64'(sw), 64'(1));
    chk("spur.sum", 64'(val_err_sum), 64'(4));
    tick();
    chk("spur.done", 64'(done), 64'(1));
    chk("spur.epoch_cnt", 64'(epoch_cnt), 64'(1));
    chk("spur.best_err", 64'(best_err), 64'(4));
    tick();
    chk("spur.end", 64'(done | busy), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
